// File: rtl/nq_writeback.sv
// Write-side driver for the NanoQuarter 8x16 register file: merges ALU results with
// in-order load returns, keeps the outstanding-load queue and a per-register busy map.
module nq_writeback #(
  parameter int LDQ_DEPTH = 4,
  parameter int DW        = 16,
  parameter int RW        = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [RW-1:0]     alu_rd,
  input  logic [DW-1:0]     alu_data,
  output logic              alu_ready,
  input  logic              ld_issue,
  input  logic [RW-1:0]     ld_rd,
  input  logic              mem_valid,
  input  logic [DW-1:0]     mem_data,
  output logic              ldq_full,
  output logic [RW-1:0]     rd,
  output logic [DW-1:0]     data_out,
  output logic              wp,
  output logic [2**RW-1:0]  busy,
  output logic              err
);

  localparam int PW = $clog2(LDQ_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(LDQ_DEPTH);

  logic [RW-1:0] queue_mem [LDQ_DEPTH];
  logic [PW-1:0] head_reg, tail_reg;
  logic [PW:0]   count_reg, count_next;
  logic          s1_valid_reg, s2_valid_reg;
  logic [RW-1:0] s1_rd_reg, s2_rd_reg;
  logic [DW-1:0] s1_data_reg, s2_data_reg;
  logic          err_reg;

  logic q_empty, push, pop, alu_win, win_valid;
  logic [RW-1:0] win_rd;
  logic [DW-1:0] win_data;
  logic [LDQ_DEPTH-1:0] entry_valid;

  assign q_empty   = (count_reg == '0);
  assign ldq_full  = (count_reg == FULL_CNT);
  // Memory cannot be stalled, so the ALU is refused whenever a return arrives,
  // even an erroneous one with the queue empty.
  assign alu_ready = !mem_valid;
  assign pop       = mem_valid && !q_empty;
  assign alu_win   = !mem_valid && alu_valid;
  assign win_valid = pop || alu_win;
  assign win_rd    = pop ? queue_mem[head_reg] : alu_rd;
  assign win_data  = pop ? mem_data : alu_data;
  // A full queue rejects a push even if the same cycle pops.
  assign push      = ld_issue && !ldq_full;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (PW+1)'(1);
      2'b01:   count_next = count_reg - (PW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) queue_mem[tail_reg] <= ld_rd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      s1_valid_reg <= 1'b0;
      s1_rd_reg    <= '0;
      s1_data_reg  <= '0;
      s2_valid_reg <= 1'b0;
      s2_rd_reg    <= '0;
      s2_data_reg  <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (push) tail_reg <= tail_reg + PW'(1);
      if (pop)  head_reg <= head_reg + PW'(1);
      count_reg    <= count_next;
      s1_valid_reg <= win_valid;
      if (win_valid) begin
        s1_rd_reg   <= win_rd;
        s1_data_reg <= win_data;
      end
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_rd_reg   <= s1_rd_reg;
        s2_data_reg <= s1_data_reg;
      end
      if ((ld_issue && ldq_full) || (mem_valid && q_empty)) err_reg <= 1'b1;
    end
  end

  // An entry is live when its distance from the head is below the occupancy.
  for (genvar gi = 0; gi < LDQ_DEPTH; gi++) begin : g_entry
    logic [PW-1:0] offset;
    assign offset          = PW'(gi) - head_reg;
    assign entry_valid[gi] = ({1'b0, offset} < count_reg);
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < LDQ_DEPTH; i++) begin
      if (entry_valid[i]) busy[queue_mem[i]] = 1'b1;
    end
    if (s1_valid_reg) busy[s1_rd_reg] = 1'b1;
    if (s2_valid_reg) busy[s2_rd_reg] = 1'b1;
  end

  assign rd       = s1_valid_reg ? s1_rd_reg : '0;
  assign data_out = s2_data_reg;
  assign wp       = s2_valid_reg;
  assign err      = err_reg;

endmodule
